// File: rtl/fp32_div_seq_if.sv
// fp32_div_seq_if
//   Operand/result handshake bundle between an issuing unit and the
//   sequential FP32 divider.
//   in_valid/in_ready  : operand pair handshake (dividend, divisor)
//   out_valid/out_ready: result handshake (quotient, flags)
//   flags = {invalid, div_by_zero, overflow, underflow}
//   master: issuing side; slave: the divider.
interface fp32_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [3:0]  flags;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, flags
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, flags
    );
endinterface

// File: rtl/fp32_div_seq.sv
// fp32_div_seq
//   Sequential IEEE-754 single-precision divider, one operation in flight.
//   Special operands resolve in one cycle; normal operands run a 25-step
//   restoring mantissa division, then normalize and pack (truncating).
//   Ports:
//     i_clk : clock, all state changes on the rising edge
//     i_rst : synchronous active-high reset
//     bus   : fp32_div_seq_if.slave (operand and result handshakes)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for an operand pair, in_ready high
//   S_ITER | one restoring division step per cycle, 25 steps
//   S_NORM | normalize quotient, range check, pack result
//   S_DONE | result presented, held until out_ready
module fp32_div_seq (
    input  logic          i_clk,
    input  logic          i_rst,
    fp32_div_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sign;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic signed [9:0]  r_exp;
    logic [31:0]        r_quotient;
    logic [3:0]         r_flags;

    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic               w_sign_in;
    logic               w_a_zero, w_a_inf, w_a_nan;
    logic               w_b_zero, w_b_inf, w_b_nan;
    logic               w_special;
    logic [31:0]        w_spec_q;
    logic [3:0]         w_spec_f;
    logic signed [9:0]  w_exp_in;
    logic               w_accept;
    logic               w_ge;
    logic [23:0]        w_diff;
    logic [24:0]        w_rem_next;
    logic signed [9:0]  w_norm_exp;
    logic [22:0]        w_frac;

    assign w_ea      = bus.dividend[30:23];
    assign w_eb      = bus.divisor[30:23];
    assign w_sign_in = bus.dividend[31] ^ bus.divisor[31];
    // Exponent field 0 is treated as zero: subnormals are flushed.
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_a_inf   = (w_ea == 8'hFF) && (bus.dividend[22:0] == 23'd0);
    assign w_a_nan   = (w_ea == 8'hFF) && (bus.dividend[22:0] != 23'd0);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (bus.divisor[22:0] == 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (bus.divisor[22:0] != 23'd0);

    // Priority order matters: inf/0 must give inf without div_by_zero.
    always_comb begin
        w_special = 1'b1;
        w_spec_q  = 32'd0;
        w_spec_f  = 4'd0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_q = 32'h7FC0_0000;
            w_spec_f = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_q = {w_sign_in, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_spec_q = {w_sign_in, 8'hFF, 23'd0};
            w_spec_f = 4'b0100;
        end else if (w_a_zero || w_b_inf) begin
            w_spec_q = {w_sign_in, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    assign w_exp_in = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    assign bus.in_ready  = (r_state == S_IDLE) && !i_rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.flags     = r_flags;
    assign w_accept      = bus.in_valid && bus.in_ready;

    // r < 2*mb always, so a successful subtraction fits in 24 bits and
    // the shifted remainder never exceeds 25 bits.
    assign w_ge       = (r_rem >= {1'b0, r_mb});
    assign w_diff     = r_rem[23:0] - r_mb;
    assign w_rem_next = w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};

    // Quotient lies in [2^23, 2^25): at most one bit of normalization.
    assign w_norm_exp = r_q[24] ? r_exp : (r_exp - 10'sd1);
    assign w_frac     = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_ITER;
            S_ITER: if (r_cnt == 5'd24) w_state_next = S_NORM;
            S_NORM: w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign     <= 1'b0;
            r_mb       <= 24'd0;
            r_rem      <= 25'd0;
            r_q        <= 25'd0;
            r_cnt      <= 5'd0;
            r_exp      <= 10'sd0;
            r_quotient <= 32'd0;
            r_flags    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign  <= w_sign_in;
                        r_mb    <= {1'b1, bus.divisor[22:0]};
                        r_rem   <= {2'b01, bus.dividend[22:0]};
                        r_q     <= 25'd0;
                        r_cnt   <= 5'd0;
                        r_exp   <= w_exp_in;
                        // Specials produce their result on the accept edge;
                        // otherwise the old result is cleared here.
                        r_quotient <= w_special ? w_spec_q : 32'd0;
                        r_flags    <= w_special ? w_spec_f : 4'd0;
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[23:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    if (w_norm_exp >= 10'sd255) begin
                        r_quotient <= {r_sign, 8'hFF, 23'd0};
                        r_flags    <= 4'b0010;
                    end else if (w_norm_exp <= 10'sd0) begin
                        r_quotient <= {r_sign, 31'd0};
                        r_flags    <= 4'b0001;
                    end else begin
                        r_quotient <= {r_sign, w_norm_exp[7:0], w_frac};
                        r_flags    <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq
//   Scoreboard bench for fp32_div_seq: the driver pushes expected results
//   (directed constants or a behavioural model), a monitor pops and
//   compares whenever a result is consumed, and also checks latency.
module tb_fp32_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 1;
    logic rnd_rdy = 1'b1;
    logic seen = 1'b0;

    typedef struct {
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    fp32_div_seq_if bus ();

    fp32_div_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
    assign bus.out_ready = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: classify operands, else integer long division of the
    // significands followed by normalization to a 24-bit significand.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [3:0] f,
                                  output int lat);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        logic s = a[31] ^ b[31];
        bit az = (ea == 0), bz = (eb == 0);
        bit ai = (ea == 255) && (a[22:0] == 0), bi = (eb == 255) && (b[22:0] == 0);
        bit an = (ea == 255) && (a[22:0] != 0), bn = (eb == 255) && (b[22:0] != 0);
        longint ma, mb, val;
        int e;
        logic [63:0] vb;
        logic [31:0] eb32;
        lat = 1;
        f = 4'd0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            q = 32'h7FC00000; f = 4'b1000;
        end else if (ai) begin
            q = {s, 8'hFF, 23'd0};
        end else if (bz) begin
            q = {s, 8'hFF, 23'd0}; f = 4'b0100;
        end else if (az || bi) begin
            q = {s, 31'd0};
        end else begin
            lat = 27;
            ma  = 64'h800000 | longint'(a[22:0]);
            mb  = 64'h800000 | longint'(b[22:0]);
            val = (ma * 64'd16777216) / mb;
            e   = ea - eb + 126;
            while (val >= 64'd16777216) begin
                val = val / 2;
                e   = e + 1;
            end
            vb   = val;
            eb32 = e;
            if (e >= 255) begin
                q = {s, 8'hFF, 23'd0}; f = 4'b0010;
            end else if (e <= 0) begin
                q = {s, 31'd0}; f = 4'b0001;
            end else begin
                q = {s, eb32[7:0], vb[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int k = $urandom_range(0, 11);
        logic s = 1'($urandom_range(0, 1));
        logic [31:0] r = $urandom;
        logic [7:0] e;
        case (k)
            0: e = 8'h00;
            1: begin e = 8'hFF; r = 32'd0; end
            2: begin e = 8'hFF; r = r | 32'd1; end
            3: e = 8'($urandom_range(1, 8));
            4: e = 8'($urandom_range(246, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, r[22:0]};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [3:0] ef, input int elat);
        int n = 0;
        exp_t x;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        #1;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            bus.in_valid = 1'b0;
            return;
        end
        x.q = eq; x.f = ef; x.lat = elat; x.acc = cyc;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (elat == 27) begin
            chk("cleared_q_on_accept", bus.quotient, 32'd0);
            chk("cleared_f_on_accept", {28'd0, bus.flags}, 32'd0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, once the
    // driver's inputs for the cycle have settled.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                if (!seen) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got quotient %h expected no output", bus.quotient);
                end
                seen = !bus.out_ready;
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
                    seen = 1'b1;
                end
                chk("in_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
                if (bus.out_ready) begin
                    chk("quotient", bus.quotient, exp_q[0].q);
                    chk("flags", {28'd0, bus.flags}, {28'd0, exp_q[0].f});
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    logic [31:0] d_a [8] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000, 32'h3F800000,
                             32'h00000000, 32'h80000000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_b [8] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000,
                             32'h00000000, 32'h40A00000, 32'h00800000, 32'h7F000000};
    logic [31:0] d_q [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000,
                             32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
    logic [3:0]  d_f [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100,
                             4'b1000, 4'b0000, 4'b0010, 4'b0001};
    int          d_l [8] = '{27, 27, 27, 1, 1, 1, 27, 27};

    initial begin
        logic [31:0] ra, rb, rq;
        logic [3:0]  rf;
        int          rl;
        int          n;
        bus.in_valid = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_flags", {28'd0, bus.flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) issue(d_a[i], d_b[i], d_q[i], d_f[i], d_l[i]);
        drain();

        // Backpressure: result held five cycles, stray in_valid ignored.
        rdy_mode = 0;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.dividend = $urandom;
            bus.divisor  = 32'h3F800000;
            #1;
            chk("bp_quotient_stable", bus.quotient, 32'h40400000);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        #1;
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        drain();

        // Reset in the middle of ITER.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("after_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (30) @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        drain();

        // Random operands against the reference model with random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            model(ra, rb, rq, rf, rl);
            issue(ra, rb, rq, rf, rl);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 1;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
